// File: rtl/color_blob_tracker.sv
// color_blob_tracker
//   Per-pixel chroma classifier with temporal history filtering and per-frame
//   bounding-box tracking for NUM_CH independent colour channels.
//   For each pixel it reads the packed history from SRAM, writes back the
//   shifted history, and flags pixels that qualify on each channel.
//   Every frame_end publishes each channel's box.
//
// Optional feature macro: CORNER_TRACK_EN
//   defined   : the extreme points of the previous frame are stored, and a
//               qualified pixel that lands on one of them reports TL/TR/BL/BR
//               (codes 1-4). Any other qualified pixel reports 5.
//   undefined : no extreme-point storage. A qualified pixel reports 5 and a
//               non-qualified pixel reports 0.
module color_blob_tracker #(
  parameter int NUM_CH   = 2,
  parameter int HIST_LEN = 4,
  parameter int CNT_W    = 3,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_end,
  input  logic                         pix_valid,
  input  logic [X_W-1:0]               pix_x,
  input  logic [Y_W-1:0]               pix_y,
  input  logic [ADDR_W-1:0]            pix_addr,
  input  logic [7:0]                   Cb,
  input  logic [7:0]                   Cr,
  input  logic [8*NUM_CH-1:0]          cb_lo,
  input  logic [8*NUM_CH-1:0]          cb_hi,
  input  logic [8*NUM_CH-1:0]          cr_lo,
  input  logic [8*NUM_CH-1:0]          cr_hi,
  input  logic [CNT_W-1:0]             hist_thresh,
  input  logic [HIST_LEN*NUM_CH-1:0]   hist_in,
  output logic [HIST_LEN*NUM_CH-1:0]   hist_out,
  output logic                         hist_we,
  output logic [ADDR_W-1:0]            hist_waddr,
  output logic [NUM_CH-1:0]            pix_hit,
  output logic [3*NUM_CH-1:0]          corner_code,
  output logic [X_W*NUM_CH-1:0]        bbox_xmin,
  output logic [X_W*NUM_CH-1:0]        bbox_xmax,
  output logic [Y_W*NUM_CH-1:0]        bbox_ymin,
  output logic [Y_W*NUM_CH-1:0]        bbox_ymax,
  output logic [NUM_CH-1:0]            bbox_valid,
  output logic                         frame_done
);

  typedef enum logic [2:0] {
    CC_NONE   = 3'd0,
    CC_TL     = 3'd1,
    CC_TR     = 3'd2,
    CC_BL     = 3'd3,
    CC_BR     = 3'd4,
    CC_MEMBER = 3'd5
  } corner_e;

  localparam logic [X_W-1:0] X_LIMIT = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] Y_LIMIT = Y_W'(V_ACTIVE);

  // Per-pixel classification
  logic                       w_in_active;
  logic [NUM_CH-1:0]          w_raw;
  logic [NUM_CH-1:0]          w_qual;
  logic [CNT_W-1:0]           w_pop [NUM_CH];
  logic [HIST_LEN*NUM_CH-1:0] w_hist_nxt;
  corner_e                    w_code [NUM_CH];

  // Running accumulators for the frame in progress, and their next values
  logic [X_W-1:0]    r_xmin [NUM_CH], r_xmax [NUM_CH];
  logic [Y_W-1:0]    r_ymin [NUM_CH], r_ymax [NUM_CH];
  logic [X_W-1:0]    w_xmin_n [NUM_CH], w_xmax_n [NUM_CH];
  logic [Y_W-1:0]    w_ymin_n [NUM_CH], w_ymax_n [NUM_CH];
  logic [NUM_CH-1:0] r_any, w_any_n;

  // Published boxes of the last completed frame
  logic [X_W-1:0]    r_bbox_xmin [NUM_CH], r_bbox_xmax [NUM_CH];
  logic [Y_W-1:0]    r_bbox_ymin [NUM_CH], r_bbox_ymax [NUM_CH];
  logic [NUM_CH-1:0] r_bbox_valid;

`ifdef CORNER_TRACK_EN
  // Each extreme point shares one coordinate with its box edge. TL sits at
  // xmin, TR at ymin, BL at ymax and BR at xmax. Only the other coordinate
  // is stored, for both the running frame and the previous one.
  logic [Y_W-1:0] r_tl_y [NUM_CH], w_tl_y_n [NUM_CH], r_ptl_y [NUM_CH];
  logic [X_W-1:0] r_tr_x [NUM_CH], w_tr_x_n [NUM_CH], r_ptr_x [NUM_CH];
  logic [X_W-1:0] r_bl_x [NUM_CH], w_bl_x_n [NUM_CH], r_pbl_x [NUM_CH];
  logic [Y_W-1:0] r_br_y [NUM_CH], w_br_y_n [NUM_CH], r_pbr_y [NUM_CH];
`endif

  // Registered per-pixel outputs
  logic [HIST_LEN*NUM_CH-1:0] r_hist_out;
  logic                       r_hist_we;
  logic [ADDR_W-1:0]          r_hist_waddr;
  logic [NUM_CH-1:0]          r_pix_hit;
  logic [3*NUM_CH-1:0]        r_corner_code;
  logic                       r_frame_done;

  // Classify the pixel on every channel and form the shifted history
  always_comb begin
    w_in_active = (pix_x < X_LIMIT) && (pix_y < Y_LIMIT);
    w_hist_nxt  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_raw[c] = (Cb >= cb_lo[8*c +: 8]) && (Cb <= cb_hi[8*c +: 8]) &&
                 (Cr >= cr_lo[8*c +: 8]) && (Cr <= cr_hi[8*c +: 8]);
      w_pop[c] = '0;
      for (int i = 0; i < HIST_LEN; i++) begin
        w_pop[c] = w_pop[c] + CNT_W'(hist_in[c*HIST_LEN + i]);
      end
      w_qual[c] = pix_valid && w_in_active && w_raw[c] && (w_pop[c] > hist_thresh);
      // The newest sample enters at bit 0 and the oldest bit drops off.
      w_hist_nxt[c*HIST_LEN +: HIST_LEN] = {hist_in[c*HIST_LEN +: HIST_LEN-1], w_raw[c]};
    end
  end

  // Fold a qualified pixel into the running extremes. Ties go to the first
  // pixel for the min edges and to the last pixel for the max edges.
  always_comb begin
    // NOTE: every output of this block gets a default before any condition,
    // so no path leaves a value unassigned and no latch is inferred.
    w_any_n = r_any;
    for (int c = 0; c < NUM_CH; c++) begin
      w_xmin_n[c] = r_xmin[c];
      w_xmax_n[c] = r_xmax[c];
      w_ymin_n[c] = r_ymin[c];
      w_ymax_n[c] = r_ymax[c];
`ifdef CORNER_TRACK_EN
      w_tl_y_n[c] = r_tl_y[c];
      w_tr_x_n[c] = r_tr_x[c];
      w_bl_x_n[c] = r_bl_x[c];
      w_br_y_n[c] = r_br_y[c];
`endif
      if (w_qual[c]) begin
        w_any_n[c] = 1'b1;
        if (pix_x < r_xmin[c]) begin
          w_xmin_n[c] = pix_x;
`ifdef CORNER_TRACK_EN
          w_tl_y_n[c] = pix_y;
`endif
        end
        if (pix_x >= r_xmax[c]) begin
          w_xmax_n[c] = pix_x;
`ifdef CORNER_TRACK_EN
          w_br_y_n[c] = pix_y;
`endif
        end
        if (pix_y < r_ymin[c]) begin
          w_ymin_n[c] = pix_y;
`ifdef CORNER_TRACK_EN
          w_tr_x_n[c] = pix_x;
`endif
        end
        if (pix_y >= r_ymax[c]) begin
          w_ymax_n[c] = pix_y;
`ifdef CORNER_TRACK_EN
          w_bl_x_n[c] = pix_x;
`endif
        end
      end
    end
  end

  // Corner code of a qualified pixel against the previous frame's extremes
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_code[c] = CC_NONE;
      if (w_qual[c]) begin
        w_code[c] = CC_MEMBER;
`ifdef CORNER_TRACK_EN
        if (r_bbox_valid[c]) begin
          if (pix_x == r_bbox_xmin[c] && pix_y == r_ptl_y[c]) begin
            w_code[c] = CC_TL;
          end else if (pix_y == r_bbox_ymin[c] && pix_x == r_ptr_x[c]) begin
            w_code[c] = CC_TR;
          end else if (pix_y == r_bbox_ymax[c] && pix_x == r_pbl_x[c]) begin
            w_code[c] = CC_BL;
          end else if (pix_x == r_bbox_xmax[c] && pix_y == r_pbr_y[c]) begin
            w_code[c] = CC_BR;
          end
        end
`endif
      end
    end
  end

  // Pixel output pipeline, accumulators and the frame_end snapshot
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, whatever the statement order.
    if (!reset) begin
      r_hist_out    <= '0;
      r_hist_we     <= 1'b0;
      r_hist_waddr  <= '0;
      r_pix_hit     <= '0;
      r_corner_code <= '0;
      r_frame_done  <= 1'b0;
      r_bbox_valid  <= '0;
      r_any         <= '0;
      // NOTE: these per-channel arrays are a handful of flops, not a RAM, so
      // resetting them is cheap. The pixel history lives in external SRAM
      // and is never cleared here.
      for (int c = 0; c < NUM_CH; c++) begin
        r_xmin[c]      <= '1;
        r_xmax[c]      <= '0;
        r_ymin[c]      <= '1;
        r_ymax[c]      <= '0;
        r_bbox_xmin[c] <= '0;
        r_bbox_xmax[c] <= '0;
        r_bbox_ymin[c] <= '0;
        r_bbox_ymax[c] <= '0;
`ifdef CORNER_TRACK_EN
        r_tl_y[c]  <= '0;
        r_tr_x[c]  <= '0;
        r_bl_x[c]  <= '0;
        r_br_y[c]  <= '0;
        r_ptl_y[c] <= '0;
        r_ptr_x[c] <= '0;
        r_pbl_x[c] <= '0;
        r_pbr_y[c] <= '0;
`endif
      end
    end else begin
      r_hist_we     <= pix_valid;
      r_hist_out    <= w_hist_nxt;
      r_hist_waddr  <= pix_addr;
      r_pix_hit     <= w_qual;
      r_frame_done  <= frame_end;
      for (int c = 0; c < NUM_CH; c++) begin
        r_corner_code[3*c +: 3] <= w_code[c];
      end
      if (frame_end) begin
        // The snapshot takes the next-state values, so a pixel arriving with
        // frame_end still belongs to the frame that is closing.
        r_bbox_valid <= w_any_n;
        r_any        <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          r_bbox_xmin[c] <= w_xmin_n[c];
          r_bbox_xmax[c] <= w_xmax_n[c];
          r_bbox_ymin[c] <= w_ymin_n[c];
          r_bbox_ymax[c] <= w_ymax_n[c];
          r_xmin[c]      <= '1;
          r_xmax[c]      <= '0;
          r_ymin[c]      <= '1;
          r_ymax[c]      <= '0;
`ifdef CORNER_TRACK_EN
          r_ptl_y[c] <= w_tl_y_n[c];
          r_ptr_x[c] <= w_tr_x_n[c];
          r_pbl_x[c] <= w_bl_x_n[c];
          r_pbr_y[c] <= w_br_y_n[c];
`endif
        end
      end else begin
        r_any <= w_any_n;
        for (int c = 0; c < NUM_CH; c++) begin
          r_xmin[c] <= w_xmin_n[c];
          r_xmax[c] <= w_xmax_n[c];
          r_ymin[c] <= w_ymin_n[c];
          r_ymax[c] <= w_ymax_n[c];
`ifdef CORNER_TRACK_EN
          r_tl_y[c] <= w_tl_y_n[c];
          r_tr_x[c] <= w_tr_x_n[c];
          r_bl_x[c] <= w_bl_x_n[c];
          r_br_y[c] <= w_br_y_n[c];
`endif
        end
      end
    end
  end

  // Flatten the per-channel box registers onto the output buses
  always_comb begin
    bbox_xmin = '0;
    bbox_xmax = '0;
    bbox_ymin = '0;
    bbox_ymax = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bbox_xmin[c*X_W +: X_W] = r_bbox_xmin[c];
      bbox_xmax[c*X_W +: X_W] = r_bbox_xmax[c];
      bbox_ymin[c*Y_W +: Y_W] = r_bbox_ymin[c];
      bbox_ymax[c*Y_W +: Y_W] = r_bbox_ymax[c];
    end
  end

  assign hist_out    = r_hist_out;
  assign hist_we     = r_hist_we;
  assign hist_waddr  = r_hist_waddr;
  assign pix_hit     = r_pix_hit;
  assign corner_code = r_corner_code;
  assign bbox_valid  = r_bbox_valid;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_color_blob_tracker.sv
// Testbench for color_blob_tracker. The stimulus side runs a frame-level
// reference model and queues expected pixel and frame results. A negedge
// monitor pops the queues whenever hist_we or frame_done is presented.
module tb_color_blob_tracker;

  localparam int NC = 2;
  localparam int HL = 4;
  localparam int CW = 3;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int AW = 19;

  logic              clk = 1'b0;
  logic              reset;
  logic              frame_end, pix_valid;
  logic [XW-1:0]     pix_x;
  logic [YW-1:0]     pix_y;
  logic [AW-1:0]     pix_addr;
  logic [7:0]        Cb, Cr;
  logic [8*NC-1:0]   cb_lo, cb_hi, cr_lo, cr_hi;
  logic [CW-1:0]     hist_thresh;
  logic [HL*NC-1:0]  hist_in, hist_out;
  logic              hist_we;
  logic [AW-1:0]     hist_waddr;
  logic [NC-1:0]     pix_hit;
  logic [3*NC-1:0]   corner_code;
  logic [XW*NC-1:0]  bbox_xmin, bbox_xmax;
  logic [YW*NC-1:0]  bbox_ymin, bbox_ymax;
  logic [NC-1:0]     bbox_valid;
  logic              frame_done;

  always #5 clk = ~clk;

  color_blob_tracker dut (
    .clk(clk), .reset(reset), .frame_end(frame_end), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_addr(pix_addr), .Cb(Cb), .Cr(Cr),
    .cb_lo(cb_lo), .cb_hi(cb_hi), .cr_lo(cr_lo), .cr_hi(cr_hi),
    .hist_thresh(hist_thresh), .hist_in(hist_in), .hist_out(hist_out),
    .hist_we(hist_we), .hist_waddr(hist_waddr), .pix_hit(pix_hit),
    .corner_code(corner_code), .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
    .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax), .bbox_valid(bbox_valid),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [HL*NC-1:0] hist;
    logic [AW-1:0]    addr;
    logic [NC-1:0]    hit;
    logic [3*NC-1:0]  code;
  } pix_exp_t;

  typedef struct packed {
    logic [XW*NC-1:0] xmin, xmax;
    logic [YW*NC-1:0] ymin, ymax;
    logic [NC-1:0]    valid;
  } frm_exp_t;

  pix_exp_t pix_q[$];
  frm_exp_t frm_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: qualified points of the open frame in arrival
  // order, and the previous frame's extreme points (0 TL, 1 TR, 2 BL, 3 BR).
  int qx[NC][$];
  int qy[NC][$];
  int prev_x[NC][4];
  int prev_y[NC][4];
  bit prev_ok[NC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      qx[c].delete();
      qy[c].delete();
      prev_ok[c] = 1'b0;
    end
  endtask

  // Evaluate the inputs currently applied and queue the expected responses
  task automatic model_cycle();
    pix_exp_t pe;
    frm_exp_t fe;
    int h, code, n, mnx, mxx, mny, mxy;
    bit raw, qual;
    pe = '0;
    fe = '0;
    if (pix_valid) begin
      for (int c = 0; c < NC; c++) begin
        h    = int'(hist_in[c*HL +: HL]);
        raw  = (Cb >= cb_lo[8*c +: 8]) && (Cb <= cb_hi[8*c +: 8]) &&
               (Cr >= cr_lo[8*c +: 8]) && (Cr <= cr_hi[8*c +: 8]);
        qual = raw && ($countones(h) > int'(hist_thresh)) &&
               (int'(pix_x) < 640) && (int'(pix_y) < 480);
        pe.hist[c*HL +: HL] = HL'((h << 1) | int'(raw));
        pe.hit[c] = qual;
        code = 0;
        if (qual) begin
          code = 5;
`ifdef CORNER_TRACK_EN
          if (prev_ok[c]) begin
            for (int k = 3; k >= 0; k--) begin
              if (prev_x[c][k] == int'(pix_x) && prev_y[c][k] == int'(pix_y)) code = k + 1;
            end
          end
`endif
          qx[c].push_back(int'(pix_x));
          qy[c].push_back(int'(pix_y));
        end
        pe.code[3*c +: 3] = code[2:0];
      end
      pe.addr = pix_addr;
      pix_q.push_back(pe);
    end
    if (frame_end) begin
      for (int c = 0; c < NC; c++) begin
        n = qx[c].size();
        mnx = 1023; mxx = 0; mny = 1023; mxy = 0;
        for (int i = 0; i < n; i++) begin
          if (qx[c][i] < mnx) mnx = qx[c][i];
          if (qx[c][i] > mxx) mxx = qx[c][i];
          if (qy[c][i] < mny) mny = qy[c][i];
          if (qy[c][i] > mxy) mxy = qy[c][i];
        end
        fe.xmin[c*XW +: XW] = XW'(mnx);
        fe.xmax[c*XW +: XW] = XW'(mxx);
        fe.ymin[c*YW +: YW] = YW'(mny);
        fe.ymax[c*YW +: YW] = YW'(mxy);
        fe.valid[c] = (n > 0);
        prev_ok[c]  = (n > 0);
        // TL/TR: first point reaching the minimum; BL/BR: last reaching the maximum.
        for (int i = n - 1; i >= 0; i--) begin
          if (qx[c][i] == mnx) begin prev_x[c][0] = mnx; prev_y[c][0] = qy[c][i]; end
          if (qy[c][i] == mny) begin prev_x[c][1] = qx[c][i]; prev_y[c][1] = mny; end
        end
        for (int i = 0; i < n; i++) begin
          if (qy[c][i] == mxy) begin prev_x[c][2] = qx[c][i]; prev_y[c][2] = mxy; end
          if (qx[c][i] == mxx) begin prev_x[c][3] = mxx; prev_y[c][3] = qy[c][i]; end
        end
        qx[c].delete();
        qy[c].delete();
      end
      frm_q.push_back(fe);
    end
  endtask

  task automatic step();
    if (reset) model_cycle();
    else       model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic fe, input int x, input int y,
                       input logic [7:0] cb, input logic [7:0] cr, input logic [HL*NC-1:0] h);
    pix_valid = v;
    frame_end = fe;
    pix_x     = XW'(x);
    pix_y     = YW'(y);
    Cb        = cb;
    Cr        = cr;
    hist_in   = h;
    pix_addr  = AW'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hist_we"},   64'(hist_we), 64'd0);
    check({tag, "_hist_out"},  64'(hist_out), 64'd0);
    check({tag, "_pix_hit"},   64'(pix_hit), 64'd0);
    check({tag, "_corner"},    64'(corner_code), 64'd0);
    check({tag, "_bbox_valid"}, 64'(bbox_valid), 64'd0);
    check({tag, "_bbox_xmax"}, 64'(bbox_xmax), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
  endtask

  // Monitor: compare every presented pixel result and frame snapshot
  pix_exp_t mon_pe;
  frm_exp_t mon_fe;
  always @(negedge clk) begin
    if (hist_we) begin
      if (pix_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_hist_we: got 1 expected 0 at %0t", $time);
      end else begin
        mon_pe = pix_q.pop_front();
        check("hist_out",    64'(hist_out),    64'(mon_pe.hist));
        check("hist_waddr",  64'(hist_waddr),  64'(mon_pe.addr));
        check("pix_hit",     64'(pix_hit),     64'(mon_pe.hit));
        check("corner_code", 64'(corner_code), 64'(mon_pe.code));
      end
    end
    if (frame_done) begin
      if (frm_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_frame_done: got 1 expected 0 at %0t", $time);
      end else begin
        mon_fe = frm_q.pop_front();
        check("bbox_xmin",  64'(bbox_xmin),  64'(mon_fe.xmin));
        check("bbox_xmax",  64'(bbox_xmax),  64'(mon_fe.xmax));
        check("bbox_ymin",  64'(bbox_ymin),  64'(mon_fe.ymin));
        check("bbox_ymax",  64'(bbox_ymax),  64'(mon_fe.ymax));
        check("bbox_valid", 64'(bbox_valid), 64'(mon_fe.valid));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int cx[5] = '{20, 100, 150, 300, 99};
  int cy[5] = '{120, 50, 400, 200, 99};
  int cc[5] = '{1, 2, 3, 4, 5};
  logic [7:0] lo8, hi8;

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 8'd0, 8'd0, '0);
    hist_thresh = 3'd2;
    cb_lo = {8'd30, 8'd0};  cb_hi = {8'd50, 8'd60};
    cr_lo = {8'd30, 8'd0};  cr_hi = {8'd50, 8'd60};
    model_reset();
    step(); step();
    check_all_zero("por");
    reset = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 8'd0, 8'd0, '0);
    step();

    // History filter: pop 3 > 2 qualifies, pop 2 does not
    drive(1'b1, 1'b0, 10, 10, 8'd40, 8'd40, {4'b0000, 4'b0111});
    step();
    check("dir_hist_0111", 64'(hist_out[3:0]), 64'hF);
    check("dir_hit_0111",  64'(pix_hit[0]), 64'd1);
    drive(1'b1, 1'b0, 10, 10, 8'd40, 8'd40, {4'b0000, 4'b0011});
    step();
    check("dir_hist_0011", 64'(hist_out[3:0]), 64'h7);
    check("dir_hit_0011",  64'(pix_hit[0]), 64'd0);
    drive(1'b0, 1'b1, 0, 0, 8'd0, 8'd0, '0);
    step();

    // Four-point frame, qualifying on both channels
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, cx[i], cy[i], 8'd40, 8'd40, {4'hF, 4'hF});
      step();
      check("dir_both_hit", 64'(pix_hit), 64'd3);
    end
    drive(1'b0, 1'b1, 0, 0, 8'd0, 8'd0, '0);
    step();
    check("dir_frame_done", 64'(frame_done), 64'd1);
    check("dir_xmin", 64'(bbox_xmin), 64'({10'd20, 10'd20}));
    check("dir_xmax", 64'(bbox_xmax), 64'({10'd300, 10'd300}));
    check("dir_ymin", 64'(bbox_ymin), 64'({10'd50, 10'd50}));
    check("dir_ymax", 64'(bbox_ymax), 64'({10'd400, 10'd400}));
    check("dir_valid", 64'(bbox_valid), 64'd3);
    drive(1'b0, 1'b0, 0, 0, 8'd0, 8'd0, '0);
    step();
    check("dir_frame_done_pulse", 64'(frame_done), 64'd0);

    // Corner codes against the previous frame
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, cx[i], cy[i], 8'd40, 8'd40, {4'hF, 4'hF});
      step();
`ifdef CORNER_TRACK_EN
      check("dir_corner_ch0", 64'(corner_code[2:0]), 64'(cc[i]));
`else
      check("dir_corner_ch0", 64'(corner_code[2:0]), 64'd5);
`endif
    end
    // Out of the active area: history written, no hit
    drive(1'b1, 1'b0, 640, 100, 8'd40, 8'd40, {4'hF, 4'hF});
    step();
    check("dir_x640_we",  64'(hist_we), 64'd1);
    check("dir_x640_hit", 64'(pix_hit), 64'd0);
    // Chroma inside only the channel 0 window
    drive(1'b1, 1'b0, 200, 300, 8'd10, 8'd10, {4'hF, 4'hF});
    step();
    check("dir_ch0_only", 64'(pix_hit), 64'd1);
    // Pixel together with frame_end joins the closing snapshot
    drive(1'b1, 1'b1, 5, 5, 8'd40, 8'd40, {4'hF, 4'hF});
    step();
    check("dir_same_cycle_xmin", 64'(bbox_xmin[9:0]), 64'd5);
    check("dir_same_cycle_ymin", 64'(bbox_ymin[9:0]), 64'd5);

    // Reset mid-frame, with pixel and frame_end also asserted
    drive(1'b1, 1'b0, 10, 10, 8'd40, 8'd40, {4'hF, 4'hF});
    step();
    drive(1'b1, 1'b0, 600, 450, 8'd40, 8'd40, {4'hF, 4'hF});
    step();
    reset = 1'b0;
    drive(1'b1, 1'b1, 300, 300, 8'd40, 8'd40, {4'hF, 4'hF});
    step(); step();
    check_all_zero("mid_reset");
    reset = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 8'd0, 8'd0, '0);
    step();
    drive(1'b1, 1'b0, 400, 300, 8'd40, 8'd40, {4'hF, 4'hF});
    step();
    check("post_reset_code", 64'(corner_code), 64'({3'd5, 3'd5}));
    drive(1'b0, 1'b1, 0, 0, 8'd0, 8'd0, '0);
    step();
    check("post_reset_xmin", 64'(bbox_xmin), 64'({10'd400, 10'd400}));
    check("post_reset_xmax", 64'(bbox_xmax), 64'({10'd400, 10'd400}));
    check("post_reset_ymin", 64'(bbox_ymin), 64'({10'd300, 10'd300}));
    check("post_reset_ymax", 64'(bbox_ymax), 64'({10'd300, 10'd300}));

    // Randomised traffic on a coarse grid so extreme points recur
    for (int cyc = 0; cyc < 4000; cyc++) begin
      drive(1'b0, 1'b0, 0, 0, 8'd0, 8'd0, '0);
      pix_valid = ($urandom_range(0, 9) < 8);
      frame_end = ($urandom_range(0, 59) == 0);
      pix_x     = XW'($urandom_range(0, 5) * 128);
      pix_y     = YW'($urandom_range(0, 4) * 120);
      Cb        = 8'($urandom);
      Cr        = 8'($urandom);
      hist_in   = (HL*NC)'($urandom);
      step();
      if (frame_end) begin
        hist_thresh = CW'($urandom_range(0, 3));
        for (int c = 0; c < NC; c++) begin
          lo8 = 8'($urandom_range(0, 80));
          hi8 = 8'($urandom_range(int'(lo8) + 100, 255));
          cb_lo[8*c +: 8] = lo8;
          cb_hi[8*c +: 8] = hi8;
          lo8 = 8'($urandom_range(0, 80));
          hi8 = 8'($urandom_range(int'(lo8) + 100, 255));
          cr_lo[8*c +: 8] = lo8;
          cr_hi[8*c +: 8] = hi8;
        end
      end
    end

    drive(1'b0, 1'b0, 0, 0, 8'd0, 8'd0, '0);
    for (int i = 0; i < 5; i++) step();
    check("pix_q_drained", 64'(pix_q.size()), 64'd0);
    check("frm_q_drained", 64'(frm_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
